sample_src: RTL
===============

SAMPLE_SRC -- requirements
Module: sample_src

Interface
REQ-001 Parameter CNT_W, default 8, width of burst-length input and remaining counter.
REQ-002 Parameter LFSR_W, fixed 16, LFSR width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset (asserted when 0).
REQ-005 start  input  1  one-cycle request to begin a burst; sampled only in IDLE.
REQ-006 seed  input  16  LFSR seed, captured on accepted start.
REQ-007 count  input  CNT_W  burst length in samples, captured on accepted start.
REQ-008 ready  input  1  downstream (mean filter) accepts sample this cycle.
REQ-009 sample  output  4  transmitted 4-bit sample = lfsr[3:0].
REQ-010 valid  output  1  sample is valid.
REQ-011 busy  output  1  burst in progress (state LOAD or SEND).
REQ-012 done  output  1  one-cycle pulse after final sample accepted or after empty burst.
REQ-013 sum  output  CNT_W+4  running sum of accepted samples in current burst.

Function
REQ-014 FSM states IDLE, LOAD, SEND, DONE; encoding in shared package.
REQ-015 IDLE: start=1 -> capture seed/count, go LOAD; start=0 -> stay.
REQ-016 LOAD (1 cycle): lfsr <= seed, or 16'h0001 if seed==0; remaining <= count; sum <= 0; count==0 -> DONE, else SEND.
REQ-017 SEND: valid=1; sample=lfsr[3:0] held stable while ready=0.
REQ-018 Transfer = valid & ready; on transfer: lfsr <= {lfsr[14:0], lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]}, remaining <= remaining-1, sum <= sum+sample.
REQ-019 Transfer with remaining==1 -> DONE; valid drops next cycle.
REQ-020 DONE (1 cycle): done=1, valid=0, then IDLE; sum holds until next LOAD.
REQ-021 start outside IDLE ignored; no queuing.
REQ-022 Latency: start at edge N -> LOAD at N+1 -> first valid at N+2.
REQ-023 Max back-to-back throughput 1 sample/cycle with ready held high.
REQ-024 sum width CNT_W+4 never overflows (max 255*15 for CNT_W=8); no wrap handling needed.
REQ-025 seed/count changes after capture have no effect on current burst.

Reset
REQ-026 rst=0 forces immediately: state IDLE, lfsr 16'h0001, remaining 0, sum 0, sample 0, valid 0, busy 0, done 0.
REQ-027 Reset mid-burst abandons burst; no done pulse; first start after release begins fresh.
REQ-028 Release of reset synchronous to clk by upstream; block adds no synchronizer.

Structure
REQ-029 Package sample_pkg: state enum, LFSR_W, tap constant 16'hB400, zero-seed substitute 16'h0001.
REQ-030 One sub-module lfsr16 (load, step, seed -> q); FSM, counter, accumulator in sample_src.
REQ-031 sample_src drives the in port of the existing mean filter directly; valid/ready stay local to source.

Verification
REQ-032 seed=0x0001, count=5, ready=1 -> samples 1,2,4,8,0 on 5 consecutive cycles; done pulse; sum=15.
REQ-033 seed=0x0000, count=2 -> behaves as seed 0x0001: samples 1,2; sum=3.
REQ-034 count=0 -> valid never asserts; done pulses 2 cycles after start; sum=0.
REQ-035 seed=0x0001, count=3, ready toggles 1,0,0,1,0,1 -> sample held during ready=0; sequence 1,2,4 unchanged; sum=7.
REQ-036 rst=0 during 3rd sample of count=10 burst -> all outputs zero at once, no done; new start seed=0x0001 count=1 -> sample 1, sum=1.
REQ-037 start pulsed while busy -> ignored; burst length and sequence unchanged.

Source files
------------

// File: rtl/sample_pkg.sv
// sample_pkg: shared definitions for the sample source.
//   state_t        - burst FSM state encoding
//   LFSR_W         - generator register width
//   LFSR_TAPS      - feedback taps (bits 15, 13, 12, 10)
//   SEED_ZERO_SUB  - value loaded instead of an all-zero seed
//   lfsr_next()    - one generator step
package sample_pkg;

    localparam int LFSR_W = 16;

    localparam logic [LFSR_W-1:0] LFSR_TAPS     = 16'hB400;
    localparam logic [LFSR_W-1:0] SEED_ZERO_SUB = 16'h0001;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SEND = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Left shift with the XOR of the tapped bits entering at bit 0.
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] q);
        return {q[LFSR_W-2:0], ^(q & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/sample_src_lfsr16.sv
// lfsr16: 16-bit Fibonacci LFSR used as the sample generator.
//   clk, rst (async, active-low) - reset value SEED_ZERO_SUB
//   load  - take seed (all-zero seed replaced by SEED_ZERO_SUB)
//   step  - advance one position (load has priority)
//   seed  - value for load
//   q     - current register contents
module lfsr16
    import sample_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              step,
    input  logic [LFSR_W-1:0] seed,
    output logic [LFSR_W-1:0] q
);

    logic [LFSR_W-1:0] r_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_q <= SEED_ZERO_SUB;
        end else if (load) begin
            // An all-zero state would lock the register at zero forever.
            r_q <= (seed == '0) ? SEED_ZERO_SUB : seed;
        end else if (step) begin
            r_q <= lfsr_next(r_q);
        end
    end

    assign q = r_q;

endmodule

// File: rtl/sample_src.sv
// sample_src: emits a burst of count 4-bit pseudo-random samples over a
// valid/ready handshake and accumulates the sum of accepted samples.
//   clk, rst (async, active-low)
//   start  - burst request, honoured only in IDLE
//   seed   - generator seed, captured with start
//   count  - burst length, captured with start (0 = empty burst)
//   ready  - downstream accepts the current sample
//   sample - low nibble of the generator while sending, else 0
//   valid  - sample is valid (SEND)
//   busy   - burst in progress (LOAD or SEND)
//   done   - one-cycle pulse when the burst completes
//   sum    - running sum of accepted samples, held until next LOAD
module sample_src #(
    parameter int CNT_W  = 8,
    parameter int LFSR_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [LFSR_W-1:0]  seed,
    input  logic [CNT_W-1:0]   count,
    input  logic               ready,
    output logic [3:0]         sample,
    output logic               valid,
    output logic               busy,
    output logic               done,
    output logic [CNT_W+3:0]   sum
);

    import sample_pkg::*;

    state_t             r_state;
    state_t             w_next;
    logic [LFSR_W-1:0]  r_seed;
    logic [CNT_W-1:0]   r_count;
    logic [CNT_W-1:0]   r_rem;
    logic [CNT_W+3:0]   r_sum;
    logic [LFSR_W-1:0]  w_lfsr;
    logic [LFSR_W-5:0]  w_lfsr_hi_unused;
    logic               w_accept;
    logic               w_load;
    logic               w_xfer;

    lfsr16 u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .load (w_load),
        .step (w_xfer),
        .seed (r_seed),
        .q    (w_lfsr)
    );

    // Only the low nibble leaves the block; the rest is generator state.
    assign w_lfsr_hi_unused = w_lfsr[LFSR_W-1:4];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_load   = 1'b0;
        w_xfer   = 1'b0;
        sample   = '0;
        valid    = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_accept = 1'b1;
                    w_next   = ST_LOAD;
                end
            end
            ST_LOAD: begin
                busy   = 1'b1;
                w_load = 1'b1;
                w_next = (r_count == '0) ? ST_DONE : ST_SEND;
            end
            ST_SEND: begin
                busy   = 1'b1;
                valid  = 1'b1;
                sample = w_lfsr[3:0];
                w_xfer = ready;
                if (ready && (r_rem == CNT_W'(1))) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE: begin
                done   = 1'b1;
                w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_seed  <= '0;
            r_count <= '0;
            r_rem   <= '0;
            r_sum   <= '0;
        end else begin
            if (w_accept) begin
                r_seed  <= seed;
                r_count <= count;
            end
            if (w_load) begin
                r_rem <= r_count;
                r_sum <= '0;
            end else if (w_xfer) begin
                r_rem <= r_rem - CNT_W'(1);
                r_sum <= r_sum + (CNT_W+4)'(sample);
            end
        end
    end

    assign sum = r_sum;

endmodule
